// File: rtl/matrix_out_pkg.sv
// Register map, FSM encoding and shape helper for the matrix output port.
package matrix_out_pkg;

  localparam logic [3:0] REG_CFG  = 4'h0;
  localparam logic [3:0] REG_DATA = 4'h4;
  localparam logic [3:0] REG_POS  = 4'h8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // A zero shape field means a single row/column, never an empty matrix.
  function automatic logic [7:0] clamp_dim(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/matrix_out_fifo.sv
// Synchronous element FIFO with registered occupancy; a push into an empty
// FIFO is only visible for popping on the following cycle.
module matrix_out_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_push,
  input  logic [DATA_W-1:0]      i_push_data,
  input  logic                   i_pop,
  output logic [DATA_W-1:0]      o_pop_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_level    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  // Element storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/matrix_out_port.sv
// Memory-mapped matrix print port: buffers element words written by firmware
// and paces them out with end-of-row / end-of-matrix markers.
module matrix_out_port
  import matrix_out_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        wr_en,
  input  logic [3:0]                  wr_addr,
  input  logic [31:0]                 wr_data,
  output logic                        wr_ready,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_matrix,
  output logic                        out_matrix_en,
  output logic                        out_matrix_end_row,
  output logic                        out_matrix_end,
  output logic [7:0]                  out_matrix_position,
  output logic                        out_matrix_position_en,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t            r_state;
  logic [7:0]        r_rows;
  logic [7:0]        r_cols;
  logic [7:0]        r_row;
  logic [7:0]        r_col;
  logic              r_busy;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_cfg_wr;
  logic              w_pos_wr;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_stream_nxt;
  logic [LW-1:0]     w_level_nxt;

  // Shape changes stall until the port is idle so a matrix never mixes shapes.
  always_comb begin
    wr_ready = 1'b1;
    case (wr_addr)
      REG_CFG:  wr_ready = !r_busy;
      REG_DATA: wr_ready = !w_full;
      default:  wr_ready = 1'b1;
    endcase
  end

  assign w_accept    = wr_en && wr_ready;
  assign w_push      = w_accept && (wr_addr == REG_DATA);
  assign w_cfg_wr    = w_accept && (wr_addr == REG_CFG);
  assign w_pos_wr    = w_accept && (wr_addr == REG_POS);
  assign w_pop       = (r_state == ST_STREAM) && !w_empty && out_ready;
  assign w_last_col  = (r_col == r_cols - 8'd1);
  assign w_last_row  = (r_row == r_rows - 8'd1);
  assign w_level_nxt = level + LW'(w_push) - LW'(w_pop);
  assign busy        = r_busy;

  // Predicts whether the FSM will be streaming next cycle, for the busy flag.
  always_comb begin
    w_stream_nxt = 1'b0;
    case (r_state)
      ST_IDLE:   w_stream_nxt = w_push || !w_empty;
      ST_STREAM: w_stream_nxt = !(w_pop && w_last_col && w_last_row);
      default:   w_stream_nxt = 1'b0;
    endcase
  end

  matrix_out_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_push),
    .i_push_data (wr_data[DATA_W-1:0]),
    .i_pop       (w_pop),
    .o_pop_data  (w_rd_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (level)
  );

  // FSM, row/column counters, shape registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state                <= ST_IDLE;
      r_rows                 <= 8'd1;
      r_cols                 <= 8'd1;
      r_row                  <= 8'd0;
      r_col                  <= 8'd0;
      r_busy                 <= 1'b0;
      out_matrix             <= '0;
      out_matrix_en          <= 1'b0;
      out_matrix_end_row     <= 1'b0;
      out_matrix_end         <= 1'b0;
      out_matrix_position    <= 8'd0;
      out_matrix_position_en <= 1'b0;
    end else begin
      if (w_cfg_wr) begin
        r_rows <= clamp_dim(wr_data[15:8]);
        r_cols <= clamp_dim(wr_data[7:0]);
      end
      if (w_pop) begin
        out_matrix <= w_rd_data;
      end
      out_matrix_en          <= w_pop;
      out_matrix_end_row     <= w_pop && w_last_col;
      out_matrix_end         <= w_pop && w_last_col && w_last_row;
      out_matrix_position_en <= w_pos_wr;
      if (w_pos_wr) begin
        out_matrix_position <= wr_data[7:0];
      end
      r_busy <= w_stream_nxt || (w_level_nxt != '0);
      case (r_state)
        ST_IDLE: begin
          r_row <= 8'd0;
          r_col <= 8'd0;
          // Leftover elements from a previous matrix also restart streaming.
          if (w_push || !w_empty) begin
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_pop) begin
            if (w_last_col) begin
              r_col <= 8'd0;
              if (w_last_row) begin
                r_row   <= 8'd0;
                r_state <= ST_IDLE;
              end else begin
                r_row <= r_row + 8'd1;
              end
            end else begin
              r_col <= r_col + 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
